// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared constants and state encoding for the receive-lane aligner
package sp_pkg;
   localparam logic [7:0] COMMA = 8'hBC;

   typedef enum logic [2:0] {
      IDLE,
      HUNT,
      BLANK,
      COUNT,
      ACTIVE
   } sp_align_state_t;
endpackage

// File: rtl/sp_align_ctrl_if.sv
// rtl/sp_align_ctrl_if.sv - byte-side bundle of the aligner; los_count present with SP_ALIGN_STATS_EN
interface sp_align_ctrl_if;
   logic [7:0] byte_in;
   logic       byte_valid_in;
   logic       slip;
   logic       active;
   logic [7:0] data_out;
   logic       valid_out;
`ifdef SP_ALIGN_STATS_EN
   logic [7:0] los_count;

   modport slave (
      input  byte_in, byte_valid_in,
      output slip, active, data_out, valid_out, los_count
   );
   modport master (
      output byte_in, byte_valid_in,
      input  slip, active, data_out, valid_out, los_count
   );
`else
   modport slave (
      input  byte_in, byte_valid_in,
      output slip, active, data_out, valid_out
   );
   modport master (
      output byte_in, byte_valid_in,
      input  slip, active, data_out, valid_out
   );
`endif
endinterface

// File: rtl/sp_gap_timer.sv
// rtl/sp_gap_timer.sv - counts consecutive non-comma bytes while the lane is active
module sp_gap_timer #(
   parameter int MAX_GAP = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expire
);
   localparam int GW = $clog2(MAX_GAP + 1);

   logic [GW-1:0] gap_cnt;

   always_ff @(posedge clk) begin
      if (reset || clr)
         gap_cnt <= '0;
      else if (inc)
         gap_cnt <= gap_cnt + 1'b1;
   end

   // High when the increment being requested is the MAX_GAP-th one.
   assign expire = inc && (gap_cnt == GW'(MAX_GAP - 1));
endmodule

// File: rtl/sp_align_ctrl.sv
// rtl/sp_align_ctrl.sv - comma hunt, bit-slip and link-state control; SP_ALIGN_STATS_EN adds los_count
module sp_align_ctrl
   import sp_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int MAX_GAP    = 64,
   parameter int SLIP_BLANK = 2
) (
   input  logic               clk_4f,
   input  logic               reset,
   sp_align_ctrl_if.slave     bus
);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(SLIP_BLANK + 1);

   sp_align_state_t state, state_n;
   logic [CW-1:0]   comma_cnt, comma_cnt_n;
   logic [BW-1:0]   blank_cnt, blank_cnt_n;
   logic            slip_q, slip_n;
   logic            active_q;
   logic [7:0]      data_q, data_n;
   logic            valid_q, valid_n;
   logic            gap_clr, gap_inc, gap_expire;
   logic            is_comma;

   assign is_comma = (bus.byte_in == COMMA);

   sp_gap_timer #(.MAX_GAP(MAX_GAP)) u_gap (
      .clk    (clk_4f),
      .reset  (reset),
      .clr    (gap_clr),
      .inc    (gap_inc),
      .expire (gap_expire)
   );

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state     <= IDLE;
         comma_cnt <= '0;
         blank_cnt <= '0;
         slip_q    <= 1'b0;
         active_q  <= 1'b0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
      end else begin
         state     <= state_n;
         comma_cnt <= comma_cnt_n;
         blank_cnt <= blank_cnt_n;
         slip_q    <= slip_n;
         active_q  <= (state_n == ACTIVE);
         data_q    <= data_n;
         valid_q   <= valid_n;
      end
   end

   always_comb begin
      state_n     = state;
      comma_cnt_n = comma_cnt;
      blank_cnt_n = blank_cnt;
      slip_n      = 1'b0;
      data_n      = data_q;
      valid_n     = 1'b0;
      gap_clr     = 1'b0;
      gap_inc     = 1'b0;
      if (bus.byte_valid_in) begin
         unique case (state)
            // The byte that wakes the FSM from IDLE is judged as a HUNT byte.
            IDLE, HUNT: begin
               if (is_comma) begin
                  if (LOCK_COUNT == 1) begin
                     state_n     = ACTIVE;
                     comma_cnt_n = '0;
                  end else begin
                     state_n     = COUNT;
                     comma_cnt_n = CW'(1);
                  end
               end else begin
                  slip_n      = 1'b1;
                  blank_cnt_n = BW'(SLIP_BLANK);
                  state_n     = BLANK;
               end
            end
            BLANK: begin
               if (blank_cnt == BW'(1)) begin
                  blank_cnt_n = '0;
                  state_n     = HUNT;
               end else begin
                  blank_cnt_n = blank_cnt - 1'b1;
               end
            end
            COUNT: begin
               if (is_comma) begin
                  if (comma_cnt + 1'b1 == CW'(LOCK_COUNT)) begin
                     comma_cnt_n = '0;
                     state_n     = ACTIVE;
                  end else begin
                     comma_cnt_n = comma_cnt + 1'b1;
                  end
               end else begin
                  comma_cnt_n = '0;
                  state_n     = HUNT;
               end
            end
            ACTIVE: begin
               if (is_comma) begin
                  gap_clr = 1'b1;
               end else begin
                  gap_inc = 1'b1;
                  if (gap_expire) begin
                     gap_clr = 1'b1;
                     state_n = HUNT;
                  end else begin
                     valid_n = 1'b1;
                     data_n  = bus.byte_in;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.slip      = slip_q;
   assign bus.active    = active_q;
   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;

`ifdef SP_ALIGN_STATS_EN
   logic [7:0] los_q;

   always_ff @(posedge clk_4f) begin
      if (reset)
         los_q <= 8'h00;
      else if (state == ACTIVE && state_n == HUNT && los_q != 8'hFF)
         los_q <= los_q + 1'b1;
   end

   assign bus.los_count = los_q;
`endif
endmodule

// File: tb/tb_sp_align_ctrl.sv
// tb/tb_sp_align_ctrl.sv - directed self-checking bench for sp_align_ctrl
module tb_sp_align_ctrl;
   import sp_pkg::*;

   logic clk_4f = 1'b0;
   logic reset  = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   sp_align_ctrl_if bus ();

   sp_align_ctrl #(.LOCK_COUNT(4), .MAX_GAP(64), .SLIP_BLANK(2)) dut (
      .clk_4f (clk_4f),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic apply_reset();
      reset = 1'b1;
      bus.byte_valid_in = 1'b0;
      bus.byte_in = 8'h00;
      @(posedge clk_4f); #1;
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      bus.byte_in = b;
      bus.byte_valid_in = 1'b1;
      @(posedge clk_4f); #1;
      bus.byte_valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.byte_valid_in = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_4f); #1;
      end
   endtask

   task automatic lock_lane();
      apply_reset();
      for (int i = 0; i < 4; i++) send(8'hBC);
   endtask

   task automatic test_reset();
      apply_reset();
      total_cnt++;
      if ({bus.slip, bus.active, bus.valid_out} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {bus.slip, bus.active, bus.valid_out});
      else pass_cnt++;
      total_cnt++;
      if (bus.data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.data_out);
      else pass_cnt++;
      total_cnt++;
      if (dut.state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
      else pass_cnt++;
   endtask

   task automatic test_lock();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         send(8'hBC);
         total_cnt++;
         if (bus.slip !== 1'b0 || bus.valid_out !== 1'b0) $display("FAIL lock_quiet[%0d]: slip=%b valid=%b want 0 0", i, bus.slip, bus.valid_out);
         else pass_cnt++;
         total_cnt++;
         if (bus.active !== (i == 3)) $display("FAIL lock_active[%0d]: got %b want %b", i, bus.active, (i == 3));
         else pass_cnt++;
      end
   endtask

   task automatic test_slip();
      apply_reset();
      send(8'h5E);
      total_cnt++;
      if (bus.slip !== 1'b1 || dut.state !== BLANK) $display("FAIL slip_pulse: slip=%b state=%0d want 1 %0d", bus.slip, dut.state, BLANK);
      else pass_cnt++;
      send(8'hBC);
      total_cnt++;
      if (bus.slip !== 1'b0 || dut.state !== BLANK) $display("FAIL slip_blank1: slip=%b state=%0d want 0 %0d", bus.slip, dut.state, BLANK);
      else pass_cnt++;
      send(8'h5E);
      total_cnt++;
      if (bus.slip !== 1'b0 || dut.state !== HUNT) $display("FAIL slip_blank2: slip=%b state=%0d want 0 %0d", bus.slip, dut.state, HUNT);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) send(8'hBC);
      total_cnt++;
      if (bus.active !== 1'b1) $display("FAIL slip_relock: active=%b want 1", bus.active);
      else pass_cnt++;
   endtask

   task automatic test_forward();
      lock_lane();
      send(8'hBC);
      total_cnt++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00) $display("FAIL fwd_comma0: valid=%b data=%h want 0 00", bus.valid_out, bus.data_out);
      else pass_cnt++;
      send(8'h12);
      total_cnt++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h12) $display("FAIL fwd_12: valid=%b data=%h want 1 12", bus.valid_out, bus.data_out);
      else pass_cnt++;
      send(8'h34);
      total_cnt++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h34) $display("FAIL fwd_34: valid=%b data=%h want 1 34", bus.valid_out, bus.data_out);
      else pass_cnt++;
      send(8'hBC);
      total_cnt++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h34 || bus.active !== 1'b1) $display("FAIL fwd_comma1: valid=%b data=%h active=%b want 0 34 1", bus.valid_out, bus.data_out, bus.active);
      else pass_cnt++;
   endtask

   task automatic test_lock_loss();
      lock_lane();
      for (int i = 0; i < 63; i++) begin
         send(8'h55);
         total_cnt++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h55 || bus.active !== 1'b1) $display("FAIL loss_fwd[%0d]: valid=%b data=%h active=%b want 1 55 1", i, bus.valid_out, bus.data_out, bus.active);
         else pass_cnt++;
      end
      send(8'h55);
      total_cnt++;
      if (bus.valid_out !== 1'b0 || bus.active !== 1'b0 || dut.state !== HUNT) $display("FAIL loss_drop: valid=%b active=%b state=%0d want 0 0 %0d", bus.valid_out, bus.active, dut.state, HUNT);
      else pass_cnt++;
`ifdef SP_ALIGN_STATS_EN
      total_cnt++;
      if (bus.los_count !== 8'd1) $display("FAIL loss_count: got %0d want 1", bus.los_count);
      else pass_cnt++;
`endif
   endtask

   task automatic test_count_abort();
      apply_reset();
      for (int i = 1; i <= 3; i++) begin
         send(8'hBC);
         idle(2);
         total_cnt++;
         if (dut.state !== COUNT || dut.comma_cnt !== i) $display("FAIL cnt_freeze[%0d]: state=%0d cnt=%0d want %0d %0d", i, dut.state, dut.comma_cnt, COUNT, i);
         else pass_cnt++;
      end
      send(8'h00);
      total_cnt++;
      if (bus.slip !== 1'b0 || bus.active !== 1'b0 || dut.state !== HUNT || dut.comma_cnt !== 0) $display("FAIL cnt_abort: slip=%b active=%b state=%0d cnt=%0d want 0 0 %0d 0", bus.slip, bus.active, dut.state, dut.comma_cnt, HUNT);
      else pass_cnt++;
      send(8'hBC);
      total_cnt++;
      if (dut.state !== COUNT || dut.comma_cnt !== 1 || bus.active !== 1'b0) $display("FAIL cnt_restart: state=%0d cnt=%0d active=%b want %0d 1 0", dut.state, dut.comma_cnt, bus.active, COUNT);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      lock_lane();
      send(8'h77);
      total_cnt++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h77) $display("FAIL mid_pre: valid=%b data=%h want 1 77", bus.valid_out, bus.data_out);
      else pass_cnt++;
      bus.byte_in = 8'h99;
      bus.byte_valid_in = 1'b1;
      reset = 1'b1;
      @(posedge clk_4f); #1;
      total_cnt++;
      if ({bus.slip, bus.active, bus.valid_out} !== 3'b000 || bus.data_out !== 8'h00 || dut.state !== IDLE) $display("FAIL mid_reset: flags=%b data=%h state=%0d want 000 00 %0d", {bus.slip, bus.active, bus.valid_out}, bus.data_out, dut.state, IDLE);
      else pass_cnt++;
      reset = 1'b0;
      bus.byte_valid_in = 1'b0;
   endtask

   initial begin
      bus.byte_in = 8'h00;
      bus.byte_valid_in = 1'b0;
      @(posedge clk_4f); #1;
      test_reset();
      test_lock();
      test_slip();
      test_forward();
      test_lock_loss();
      test_count_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
